uop_queue: RTL

- Decoupling FIFO between decode and rename/ROB allocation.
- Accepts up to INSTR_Q_WIDTH decoded uop_insn entries per cycle from decode and presents up to INSTR_Q_WIDTH oldest entries per cycle to rename.
- Circular buffer of INSTR_Q_DEPTH entries with head/tail pointers and an occupancy counter.
- Flushed wholesale on a branch mispredict or exception redirect.

---
 rtl/uop_pkg.sv | 24 ++
 rtl/prefix_len.sv | 18 +
 rtl/uop_queue.sv | 69 ++++++
 3 files changed

// File: rtl/uop_pkg.sv
// uop_pkg: shared uop types and instruction-queue sizing constants
package uop_pkg;
    localparam int INSTR_Q_DEPTH = 32;
    localparam int INSTR_Q_WIDTH = 4;
    localparam int INSTR_Q_CNT_W = $clog2(INSTR_Q_DEPTH + 1);

    typedef enum logic [3:0] {
        UOP_NOP, UOP_ADD, UOP_SUB, UOP_AND, UOP_OR, UOP_XOR,
        UOP_LD, UOP_ST, UOP_BR, UOP_JMP, UOP_HLT
    } uop_code;

    typedef struct packed {
        logic [31:0] taken;
        logic [31:0] not_taken;
    } uop_data;

    typedef struct packed {
        uop_code     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        uop_data     data;
    } uop_insn;
endpackage

// File: rtl/prefix_len.sv
// prefix_len: length of the contiguous run of 1s starting at bit 0
module prefix_len #(
    parameter int W = 4
) (
    input  logic [W-1:0]           vec,
    output logic [$clog2(W+1)-1:0] len
);
    localparam int LW = $clog2(W + 1);
    logic run;
    always_comb begin
        len = '0;
        run = 1'b1;
        for (int i = 0; i < W; i++) begin
            run = run & vec[i];
            len = len + LW'(run);
        end
    end
endmodule

// File: rtl/uop_queue.sv
// uop_queue: multi-lane circular FIFO decoupling decode from rename
module uop_queue
    import uop_pkg::*;
#(
    parameter int DEPTH = INSTR_Q_DEPTH,
    parameter int WIDTH = INSTR_Q_WIDTH
) (
    input  logic                         clk_in,
    input  logic                         rst_N_in,
    input  logic                         flush_in,
    input  logic [WIDTH-1:0]             enq_valid_in,
    input  uop_insn [WIDTH-1:0]          enq_uop_in,
    output logic                         enq_ready_out,
    output logic [WIDTH-1:0]             deq_valid_out,
    output uop_insn [WIDTH-1:0]          deq_uop_out,
    input  logic [WIDTH-1:0]             deq_accept_in,
    output logic [$clog2(DEPTH+1)-1:0]   count_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(WIDTH + 1);

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [NW-1:0] n_enq, n_deq, n_enq_f;
    logic          enq_fire;
    uop_insn       mem [DEPTH];

    prefix_len #(.W(WIDTH)) u_enq_len (.vec(enq_valid_in), .len(n_enq));
    prefix_len #(.W(WIDTH)) u_deq_len (.vec(deq_accept_in & deq_valid_out), .len(n_deq));

    // readiness looks only at registered occupancy; no credit for same-cycle dequeue
    assign enq_ready_out = (CW'(DEPTH) - count) >= CW'(WIDTH);
    assign enq_fire      = enq_ready_out && !flush_in;
    assign n_enq_f       = enq_fire ? n_enq : '0;
    assign count_out     = count;

    for (genvar g = 0; g < WIDTH; g++) begin : g_deq
        assign deq_valid_out[g] = CW'(g) < count;
        assign deq_uop_out[g]   = mem[head + PW'(g)];
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < WIDTH; i++)
            if (NW'(i) < n_enq_f)
                mem[tail + PW'(i)] <= enq_uop_in[i];
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_deq);
            tail  <= tail + PW'(n_enq_f);
            count <= count + CW'(n_enq_f) - CW'(n_deq);
        end
    end

    a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_N_in) count <= CW'(DEPTH));
    a_no_underflow: assert property (@(posedge clk_in) disable iff (!rst_N_in) count >= CW'(n_deq));
    a_accept_subset: assert property (@(posedge clk_in) disable iff (!rst_N_in)
        (deq_accept_in & ~deq_valid_out) == '0);
endmodule
